// File: rtl/hwag_cap_cond_if.sv
// rtl/hwag_cap_cond_if.sv - signal bundle for hwag_cap_cond; glitch_cnt present only with HWAG_CAP_GLITCH_CNT_EN
interface hwag_cap_cond_if #(
    parameter int FILT_W = 8,
    parameter int PER_W  = 24
);
    logic              cap_raw;
    logic              cap_edge_sel;
    logic [FILT_W-1:0] filt_len;
    logic [PER_W-1:0]  stall_lim;
    logic              cap;
    logic              cap_edge;
    logic [PER_W-1:0]  period;
    logic              period_vld;
    logic              stall;
`ifdef HWAG_CAP_GLITCH_CNT_EN
    logic [15:0]       glitch_cnt;

    modport master (
        output cap_raw, cap_edge_sel, filt_len, stall_lim,
        input  cap, cap_edge, period, period_vld, stall, glitch_cnt
    );

    modport slave (
        input  cap_raw, cap_edge_sel, filt_len, stall_lim,
        output cap, cap_edge, period, period_vld, stall, glitch_cnt
    );
`else
    modport master (
        output cap_raw, cap_edge_sel, filt_len, stall_lim,
        input  cap, cap_edge, period, period_vld, stall
    );

    modport slave (
        input  cap_raw, cap_edge_sel, filt_len, stall_lim,
        output cap, cap_edge, period, period_vld, stall
    );
`endif
endinterface

// File: rtl/hwag_cap_cond.sv
// rtl/hwag_cap_cond.sv - crank capture conditioner (sync, glitch filter, tooth period, stall); HWAG_CAP_GLITCH_CNT_EN adds glitch_cnt
module hwag_cap_cond #(
    parameter int FILT_W = 8,
    parameter int PER_W  = 24
) (
    input  logic           clk,
    input  logic           rst,
    hwag_cap_cond_if.slave cc
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    logic              sync1, sync2;
    logic [FILT_W-1:0] fcnt;
    logic [FILT_W-1:0] flen_eff;
    logic [FILT_W:0]   fcnt_inc;
    logic              diff, toggle;
    logic              cap_q, cap_edge_q;
    logic [PER_W-1:0]  pcnt;
    state_t            state_q, state_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic              vld_q, vld_d;
    logic              stall_q, stall_d;
    logic              stall_hit;

    // Filter length of zero behaves as one; the >= compare keeps a shortened filt_len from missing its match
    always_comb begin
        flen_eff = (cc.filt_len == '0) ? {{(FILT_W-1){1'b0}}, 1'b1} : cc.filt_len;
        fcnt_inc = {1'b0, fcnt} + 1'b1;
        diff     = sync2 ^ cap_q;
        toggle   = diff && (fcnt_inc >= {1'b0, flen_eff});
    end

    // Two-flop synchroniser for the asynchronous comparator output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= cc.cap_raw;
            sync2 <= sync1;
        end
    end

    // Stability filter: a new level must persist flen_eff clocks before cap follows it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt       <= '0;
            cap_q      <= 1'b0;
            cap_edge_q <= 1'b0;
        end else begin
            cap_edge_q <= toggle && ((~cap_q) == cc.cap_edge_sel);
            if (toggle) begin
                cap_q <= ~cap_q;
                fcnt  <= '0;
            end else if (diff) begin
                fcnt  <= fcnt_inc[FILT_W-1:0];
            end else begin
                fcnt  <= '0;
            end
        end
    end

    // Clocks since the last selected edge; restarts at 1 after an edge and sticks at full scale
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (cap_edge_q) begin
            pcnt <= {{(PER_W-1){1'b0}}, 1'b1};
        end else if (pcnt != '1) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign stall_hit = (cc.stall_lim != '0) && (pcnt == cc.stall_lim);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            period_q <= '0;
            vld_q    <= 1'b0;
            stall_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            vld_q    <= vld_d;
            stall_q  <= stall_d;
        end
    end

    // Next state: an edge always keeps or enters RUN, so a coincident stall condition loses
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cap_edge_q) state_d = RUN;
            RUN:     if (!cap_edge_q && stall_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode: the first edge out of IDLE only re-arms timing and clears stall
    always_comb begin
        period_d = period_q;
        vld_d    = 1'b0;
        stall_d  = stall_q;
        case (state_q)
            IDLE: begin
                if (cap_edge_q) stall_d = 1'b0;
            end
            RUN: begin
                if (cap_edge_q) begin
                    vld_d    = 1'b1;
                    period_d = pcnt;
                end else if (stall_hit) begin
                    stall_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef HWAG_CAP_GLITCH_CNT_EN
    logic [15:0] glitch_q;

    // Count filter restarts that discard a partial count without toggling cap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_q <= '0;
        end else if (!diff && (fcnt != '0) && (glitch_q != 16'hFFFF)) begin
            glitch_q <= glitch_q + 16'd1;
        end
    end

    assign cc.glitch_cnt = glitch_q;
`endif

    assign cc.cap        = cap_q;
    assign cc.cap_edge   = cap_edge_q;
    assign cc.period     = period_q;
    assign cc.period_vld = vld_q;
    assign cc.stall      = stall_q;
endmodule

// File: doc/hwag_cap_cond.md
HWAG_CAP_COND -- requirements
Module: hwag_cap_cond

Interface
REQ-001 SHALL have parameter FILT_W, default 8, width of filter length input and filter counter.
REQ-002 SHALL have parameter PER_W, default 24, width of period counter, period output and stall limit.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cap_raw  input  1  unsynchronised crank VR comparator output.
REQ-006 SHALL have port cap_edge_sel  input  1  1 = rising edge of filtered signal is the tooth edge, 0 = falling.
REQ-007 SHALL have port filt_len  input  FILT_W  clocks a new level must be stable before acceptance (0 treated as 1).
REQ-008 SHALL have port stall_lim  input  PER_W  clocks without a tooth edge before stall (0 = stall detection off).
REQ-009 SHALL have port cap  output  1  filtered level; feeds hwag_core cap.
REQ-010 SHALL have port cap_edge  output  1  one-clock pulse on each selected edge of cap.
REQ-011 SHALL have port period  output  PER_W  clocks between the last two selected edges.
REQ-012 SHALL have port period_vld  output  1  one-clock pulse when period is updated.
REQ-013 SHALL have port stall  output  1  level; no selected edge within stall_lim clocks.

Function
REQ-014 SHALL pass cap_raw through a 2-flop synchroniser (sync2).
REQ-015 Filter: counter increments each clock sync2 != cap; cleared any clock sync2 == cap; cap toggles and counter clears on the clock the count reaches max(filt_len,1).
REQ-016 Raw-to-cap latency SHALL be exactly 2 + max(filt_len,1) clocks for a clean step.
REQ-017 A sync2 pulse shorter than max(filt_len,1) clocks SHALL leave cap unchanged.
REQ-018 cap_edge SHALL be registered, asserted in the same cycle cap takes the new level matching cap_edge_sel, and never held more than one clock.
REQ-019 Period counter: loads 1 on a cap_edge cycle, else increments by 1, saturating at 2^PER_W-1 (no wrap).
REQ-020 For edges at cycles t1 and t2, period SHALL equal t2-t1 (saturated), with period_vld pulsing one clock after t2.
REQ-021 State machine IDLE/RUN: IDLE + cap_edge -> RUN, no period_vld; RUN + cap_edge -> RUN, period_vld; RUN + counter == stall_lim (stall_lim != 0) -> IDLE, stall set.
REQ-022 stall SHALL clear on the next cap_edge; that edge produces no period_vld.
REQ-023 cap_edge and stall condition in the same cycle: edge wins, period reported, stall not set.
REQ-024 A change of cap_edge_sel SHALL take effect the next clock and generate no cap_edge by itself.
REQ-025 A change of filt_len or stall_lim SHALL take effect the next clock.

Reset
REQ-026 While rst = 0: sync2, cap, cap_edge, period, period_vld, stall, filter counter, period counter = 0, state = IDLE.
REQ-027 Reset assertion mid-pulse or mid-period SHALL discard all progress; the first edge after release is treated as IDLE.
REQ-028 If cap_raw is high at reset release, cap SHALL rise after REQ-016 latency; with cap_edge_sel = 1 this yields one cap_edge.

Configuration
REQ-029 With HWAG_CAP_GLITCH_CNT_EN defined, the block SHALL add output glitch_cnt [15:0], incremented (saturating at 0xFFFF) each clock the filter counter is cleared from nonzero without a toggle, reset to 0.
REQ-030 Without HWAG_CAP_GLITCH_CNT_EN, glitch_cnt and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 filt_len=4, cap_raw 0->1 step at cycle 100 -> cap = 1 at cycle 106, cap_edge one clock at 106 with cap_edge_sel=1.
REQ-032 filt_len=4, 3-clock high glitch on cap_raw -> cap stays 0, no cap_edge; with macro glitch_cnt = 1.
REQ-033 Clean 58-tooth train, edges every 128 clocks then 384-clock gap -> first edge no period_vld, then period = 128, gap edge period = 384.
REQ-034 stall_lim=1000, edges stop -> stall = 1 exactly 1000 clocks after last edge; next edge clears stall, no period_vld; following edge 128 later gives period = 128.
REQ-035 PER_W=8, edges 300 clocks apart -> period = 255.
REQ-036 rst low for 3 clocks mid-period -> all outputs 0; next edge gives no period_vld.
